// File: rtl/alu_req_arbiter_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | alu_req_arbiter_pkg : shared constants and types for the arbiter |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package alu_req_arbiter_pkg;

   localparam logic ALU_OP_ADD = 1'b0;
   localparam logic ALU_OP_SUB = 1'b1;

   localparam int RESULT_W = 5;
   localparam int OPND_W   = 2;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   typedef struct packed {
      logic [OPND_W-1:0] a;
      logic [OPND_W-1:0] b;
      logic              op;
      logic              id;
   } cmd_t;

endpackage
`default_nettype wire

// File: rtl/alu_req_arbiter_alu.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ALU_4A_2B : result = (4*A +/- 2*B) mod 32                         |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module ALU_4A_2B
   import alu_req_arbiter_pkg::*;
(
   input  logic [OPND_W-1:0]   a,
   input  logic [OPND_W-1:0]   b,
   input  logic                op,
   output logic [RESULT_W-1:0] p
);

   logic [RESULT_W-1:0] w_a4;
   logic [RESULT_W-1:0] w_b2;

   assign w_a4 = {1'b0, a, 2'b00};
   assign w_b2 = {2'b00, b, 1'b0};

   // Subtraction wraps modulo 32, matching two's-complement of 2*B.
   assign p = (op == ALU_OP_SUB) ? (w_a4 - w_b2) : (w_a4 + w_b2);

endmodule
`default_nettype wire

// File: rtl/alu_req_arbiter_pick2.sv
`default_nettype none
// +------------------------------------------------------------------+
// | alu_rr_pick2 : two-way round-robin grant selection               |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module alu_rr_pick2 (
   input  logic rr_ptr,
   input  logic valid0,
   input  logic valid1,
   output logic grant,
   output logic grant_any
);

   always_comb begin
      grant = 1'b0;
      if (rr_ptr) begin
         grant = valid1 ? 1'b1 : ~valid0;
      end else begin
         grant = ~valid0 & valid1;
      end
   end

   assign grant_any = valid0 | valid1;

endmodule
`default_nettype wire

// File: rtl/alu_req_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | alu_req_arbiter : two requesters sharing one ALU_4A_2B datapath  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module alu_req_arbiter
   import alu_req_arbiter_pkg::*;
#(
   parameter int LAT   = 2,
   parameter int CNT_W = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                req0_valid,
   output logic                req0_ready,
   input  logic [OPND_W-1:0]   req0_a,
   input  logic [OPND_W-1:0]   req0_b,
   input  logic                req0_op,
   input  logic                req1_valid,
   output logic                req1_ready,
   input  logic [OPND_W-1:0]   req1_a,
   input  logic [OPND_W-1:0]   req1_b,
   input  logic                req1_op,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic                rsp_id,
   output logic [RESULT_W-1:0] rsp_data,
   output logic                busy,
   output logic [CNT_W-1:0]    done_cnt
);

   localparam int              WAIT_W    = (LAT > 1) ? $clog2(LAT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(LAT - 1);

   logic [1:0]          r_state;
   logic                r_rr_ptr;
   logic [WAIT_W-1:0]   r_wait_cnt;
   cmd_t                r_cmd;
   cmd_t                w_cmd_in;
   logic                w_grant;
   logic                w_grant_any;
   logic                w_idle;
   logic [RESULT_W-1:0] w_alu_p;

   alu_rr_pick2 u_pick (
      .rr_ptr    (r_rr_ptr),
      .valid0    (req0_valid),
      .valid1    (req1_valid),
      .grant     (w_grant),
      .grant_any (w_grant_any)
   );

   ALU_4A_2B u_alu (
      .a  (r_cmd.a),
      .b  (r_cmd.b),
      .op (r_cmd.op),
      .p  (w_alu_p)
   );

   assign w_idle     = (r_state == ST_IDLE);
   assign req0_ready = w_idle & ~w_grant & req0_valid;
   assign req1_ready = w_idle &  w_grant & req1_valid;
   assign busy       = ~w_idle;

   always_comb begin
      w_cmd_in = '0;
      if (w_grant) begin
         w_cmd_in = '{a: req1_a, b: req1_b, op: req1_op, id: 1'b1};
      end else begin
         w_cmd_in = '{a: req0_a, b: req0_b, op: req0_op, id: 1'b0};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_rr_ptr   <= 1'b0;
         r_wait_cnt <= '0;
         r_cmd      <= '0;
         rsp_valid  <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_data   <= '0;
         done_cnt   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_grant_any) begin
                  r_cmd      <= w_cmd_in;
                  r_wait_cnt <= WAIT_LOAD;
                  r_state    <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               if (r_wait_cnt == '0) begin
                  rsp_data  <= w_alu_p;
                  rsp_id    <= r_cmd.id;
                  rsp_valid <= 1'b1;
                  r_state   <= ST_RESP;
               end else begin
                  r_wait_cnt <= r_wait_cnt - 1'b1;
               end
            end
            ST_RESP: begin
               // Pointer moves to the other requester so a waiting loser goes next.
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  done_cnt  <= done_cnt + 1'b1;
                  r_rr_ptr  <= ~rsp_id;
                  r_state   <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
